da_lut_sched: RTL and testbench

- Sequencer for the LUT-split distributed-arithmetic MAC datapath.
- Accepts a K-weight set over a valid/ready handshake and drives the LUT rebuild: one weight-load strobe, then 16 entry writes shared by all K/4 four-input sub-LUTs.
- Accepts K-element input vectors and streams their bit-planes MSB-first to the LUT address path, with accumulator control (clear, subtract, result strobe).
- Sits between the weight/activation stimulus sources (random_gen on the bench) and the LUT and accumulator datapath.

---
 rtl/da_lut_sched.sv | 161 ++++++++++++++++
 tb/tb_da_lut_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_lut_sched.sv
// da_lut_sched: sequencer for the LUT-split distributed-arithmetic MAC.
// Accepts a weight set, strobes it into the LUT builder and walks the 16
// shared sub-LUT entries. Then it streams the bit-planes of each input
// vector MSB-first, driving the accumulator clear, subtract and result
// strobes. Every output except the two ready signals is a flop.
module da_lut_sched #(
    parameter int K            = 8,
    parameter int DATA_WIDTH_B = 8,
    parameter int DATA_WIDTH_X = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [K*DATA_WIDTH_B-1:0] w_data,
    input  logic                      x_valid,
    output logic                      x_ready,
    input  logic [K*DATA_WIDTH_X-1:0] x_data,
    output logic [K*DATA_WIDTH_B-1:0] b_data,
    output logic                      b_load,
    output logic                      lut_wr_en,
    output logic [3:0]                lut_wr_idx,
    output logic                      plane_valid,
    output logic [K-1:0]              bitplane,
    output logic                      acc_clr,
    output logic                      acc_sub,
    output logic                      y_valid,
    output logic                      w_loaded,
    output logic                      busy
);

    localparam int JW = $clog2(DATA_WIDTH_X);
    localparam logic [JW-1:0] J_TOP = JW'(DATA_WIDTH_X - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_BUILD, S_READY, S_COMPUTE, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [K*DATA_WIDTH_B-1:0] b_data_q, b_data_d;
    logic [K*DATA_WIDTH_X-1:0] x_q, x_d;
    logic [JW-1:0]             j_q, j_d;
    logic [3:0]                idx_q, idx_d;
    logic [K-1:0]              bp_q, bp_d;
    logic                      wl_q, wl_d;
    logic                      b_load_q, wr_en_q, pv_q, clr_q, sub_q, yv_q, busy_q;
    logic                      w_hs, x_hs;

    // Bit j of every input element, i.e. one bit-plane of the vector.
    function automatic logic [K-1:0] plane_of(input logic [K*DATA_WIDTH_X-1:0] xv,
                                              input logic [JW-1:0] j);
        logic [K-1:0]              p;
        logic [DATA_WIDTH_X-1:0]   xi;
        p = '0;
        for (int i = 0; i < K; i++) begin
            xi   = xv[i*DATA_WIDTH_X +: DATA_WIDTH_X];
            p[i] = xi[j];
        end
        return p;
    endfunction

    // Weight updates take priority: x is only accepted when no weight set is offered.
    assign w_ready = (state_q == S_IDLE) || (state_q == S_READY);
    assign x_ready = (state_q == S_READY) && !w_valid;
    assign w_hs    = w_valid && w_ready;
    assign x_hs    = x_valid && x_ready;

    // Next-state logic for the sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (w_hs) state_d = S_LOAD_W;
            S_READY: begin
                if (w_hs)      state_d = S_LOAD_W;
                else if (x_hs) state_d = S_COMPUTE;
            end
            S_LOAD_W:  state_d = S_BUILD;
            S_BUILD:   if (idx_q == 4'd15) state_d = S_READY;
            S_COMPUTE: if (j_q == '0) state_d = S_DONE;
            S_DONE:    state_d = S_READY;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next values of the captured data, counters and the held LUT index / plane.
    always_comb begin
        b_data_d = b_data_q;
        x_d      = x_q;
        j_d      = j_q;
        idx_d    = idx_q;
        bp_d     = bp_q;
        wl_d     = wl_q;
        if (w_hs) begin
            b_data_d = w_data;
            wl_d     = 1'b0;
        end
        if (state_q == S_LOAD_W) begin
            idx_d = 4'd0;
        end else if (state_q == S_BUILD) begin
            if (idx_q == 4'd15) wl_d = 1'b1;
            else                idx_d = idx_q + 4'd1;
        end
        if (x_hs) begin
            x_d  = x_data;
            j_d  = J_TOP;
            bp_d = plane_of(x_data, J_TOP);
        end else if (state_q == S_COMPUTE && j_q != '0) begin
            j_d  = j_q - JW'(1);
            bp_d = plane_of(x_q, j_q - JW'(1));
        end
    end

    // State and registered outputs; strobes are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            b_data_q <= '0;
            x_q      <= '0;
            j_q      <= '0;
            idx_q    <= '0;
            bp_q     <= '0;
            wl_q     <= 1'b0;
            b_load_q <= 1'b0;
            wr_en_q  <= 1'b0;
            pv_q     <= 1'b0;
            clr_q    <= 1'b0;
            sub_q    <= 1'b0;
            yv_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_data_q <= b_data_d;
            x_q      <= x_d;
            j_q      <= j_d;
            idx_q    <= idx_d;
            bp_q     <= bp_d;
            wl_q     <= wl_d;
            b_load_q <= (state_d == S_LOAD_W);
            wr_en_q  <= (state_d == S_BUILD);
            pv_q     <= (state_d == S_COMPUTE);
            clr_q    <= x_hs;
            sub_q    <= x_hs;
            yv_q     <= (state_d == S_DONE);
            busy_q   <= (state_d != S_IDLE) && (state_d != S_READY);
        end
    end

    assign b_data      = b_data_q;
    assign b_load      = b_load_q;
    assign lut_wr_en   = wr_en_q;
    assign lut_wr_idx  = idx_q;
    assign plane_valid = pv_q;
    assign bitplane    = bp_q;
    assign acc_clr     = clr_q;
    assign acc_sub     = sub_q;
    assign y_valid     = yv_q;
    assign w_loaded    = wl_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_da_lut_sched.sv
// Bench for da_lut_sched: randomized weight sets and input vectors, with a
// queue of expected strobe events (cycle, index, plane bits, dot product)
// consumed by an independent negedge monitor.
module tb_da_lut_sched;

    localparam int K  = 8;
    localparam int DB = 8;
    localparam int DX = 8;
    localparam int EV_BLOAD = 0, EV_WR = 1, EV_PLANE = 2, EV_Y = 3;
    localparam int NEVER = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              w_valid = 1'b0, x_valid = 1'b0;
    logic              w_ready, x_ready;
    logic [K*DB-1:0]   w_data = '0;
    logic [K*DX-1:0]   x_data = '0;
    logic [K*DB-1:0]   b_data;
    logic              b_load, lut_wr_en, plane_valid, acc_clr, acc_sub, y_valid, w_loaded, busy;
    logic [3:0]        lut_wr_idx;
    logic [K-1:0]      bitplane;

    typedef struct {
        int           kind;
        int           cyc;
        logic [K-1:0] bits;
        logic         clr;
        logic         sub;
        int           idx;
        logic [K*DB-1:0] bdata;
        longint       y;
    } ev_t;

    ev_t             sb[$];
    int              errors = 0;
    int              checks = 0;
    int              cyc = 0;
    int              wl_on = NEVER;
    logic [K*DB-1:0] cur_wd = '0;
    longint          acc = 0;
    longint          lutv;

    always #5 clk = ~clk;

    da_lut_sched #(.K(K), .DATA_WIDTH_B(DB), .DATA_WIDTH_X(DX)) dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .b_data(b_data), .b_load(b_load),
        .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx),
        .plane_valid(plane_valid), .bitplane(bitplane),
        .acc_clr(acc_clr), .acc_sub(acc_sub), .y_valid(y_valid),
        .w_loaded(w_loaded), .busy(busy)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within the cycle budget (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops one expected event per active strobe and checks w_loaded every cycle.
    always @(negedge clk) begin
        int  n;
        int  kind;
        ev_t e;
        check("w_loaded", w_loaded, longint'(cyc >= wl_on));
        if (plane_valid) begin
            lutv = 0;
            for (int i = 0; i < K; i++)
                if (bitplane[i]) lutv += longint'($signed(b_data[i*DB +: DB]));
            if (acc_sub) lutv = -lutv;
            acc = acc_clr ? lutv : 2 * acc + lutv;
        end
        n    = int'(b_load) + int'(lut_wr_en) + int'(plane_valid) + int'(y_valid);
        kind = b_load ? EV_BLOAD : lut_wr_en ? EV_WR : plane_valid ? EV_PLANE : EV_Y;
        if (n > 1) begin
            check("one_strobe_per_cycle", n, 1);
        end else if (n == 1) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe_kind", kind, -1);
            end else begin
                e = sb.pop_front();
                check("ev_kind", kind, e.kind);
                check("ev_cycle", cyc, e.cyc);
                if (kind == e.kind) begin
                    case (kind)
                        EV_BLOAD: check("b_data", b_data, e.bdata);
                        EV_WR:    check("lut_wr_idx", lut_wr_idx, e.idx);
                        EV_PLANE: begin
                            check("bitplane", bitplane, e.bits);
                            check("acc_clr", acc_clr, e.clr);
                            check("acc_sub", acc_sub, e.sub);
                        end
                        default:  check("dot_product", acc, e.y);
                    endcase
                end
            end
        end
    end

    task automatic push_w(input logic [K*DB-1:0] wd, input int hs);
        ev_t e;
        e = '{default: 0};
        e.kind = EV_BLOAD; e.cyc = hs + 1; e.bdata = wd;
        sb.push_back(e);
        for (int k = 0; k < 16; k++) begin
            e = '{default: 0};
            e.kind = EV_WR; e.cyc = hs + 2 + k; e.idx = k;
            sb.push_back(e);
        end
        wl_on  = hs + 18;
        cur_wd = wd;
    endtask

    task automatic push_x(input logic [K*DX-1:0] xd, input int hs);
        ev_t    e;
        longint y = 0;
        for (int i = 0; i < K; i++)
            y += longint'($signed(cur_wd[i*DB +: DB])) * longint'($signed(xd[i*DX +: DX]));
        for (int j = DX - 1; j >= 0; j--) begin
            e = '{default: 0};
            e.kind = EV_PLANE; e.cyc = hs + DX - j;
            for (int i = 0; i < K; i++) e.bits[i] = xd[i*DX + j];
            e.clr = (j == DX - 1); e.sub = (j == DX - 1);
            sb.push_back(e);
        end
        e = '{default: 0};
        e.kind = EV_Y; e.cyc = hs + DX + 1; e.y = y;
        sb.push_back(e);
    endtask

    task automatic load_w(input logic [K*DB-1:0] wd, output int hs);
        w_data = wd; w_valid = 1'b1; hs = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (w_ready) begin hs = cyc; break; end
        end
        if (hs < 0) timeout("w_handshake");
        else        push_w(wd, hs);
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [K*DX-1:0] xd, output int hs, input bit keep);
        x_data = xd; x_valid = 1'b1; hs = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (x_ready) begin hs = cyc; break; end
        end
        if (hs < 0) timeout("x_handshake");
        else        push_x(xd, hs);
        @(posedge clk); #1;
        if (!keep) x_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge clk);
        check("queue_drained", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic at_neg(input int n);
        for (int t = 0; t < 300; t++) begin
            @(negedge clk); #1;
            if (cyc >= n) break;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_b_data"}, b_data, 0);
        check({tag, "_b_load"}, b_load, 0);
        check({tag, "_lut_wr_en"}, lut_wr_en, 0);
        check({tag, "_lut_wr_idx"}, lut_wr_idx, 0);
        check({tag, "_plane_valid"}, plane_valid, 0);
        check({tag, "_bitplane"}, bitplane, 0);
        check({tag, "_acc_clr"}, acc_clr, 0);
        check({tag, "_acc_sub"}, acc_sub, 0);
        check({tag, "_y_valid"}, y_valid, 0);
        check({tag, "_w_loaded"}, w_loaded, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_x_ready"}, x_ready, 0);
        check({tag, "_w_ready"}, w_ready, 1);
    endtask

    task automatic idle_x_probe(input string tag);
        for (int i = 0; i < K; i++) x_data[i*DX +: DX] = DX'($urandom);
        x_valid = 1'b1;
        repeat (6) begin
            @(negedge clk); #1;
            check({tag, "_x_ready"}, x_ready, 0);
            check({tag, "_busy"}, busy, 0);
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    function automatic logic [K*DB-1:0] rand_w();
        logic [K*DB-1:0] v;
        for (int i = 0; i < K; i++) v[i*DB +: DB] = DB'($urandom);
        return v;
    endfunction

    function automatic logic [K*DX-1:0] rand_x();
        logic [K*DX-1:0] v;
        for (int i = 0; i < K; i++) v[i*DX +: DX] = DX'($urandom);
        return v;
    endfunction

    initial begin
        int              hw, hx, h1, h2, h3;
        logic [K*DB-1:0] wd;
        logic [K*DX-1:0] xd;

        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        idle_x_probe("idle_no_weights");

        for (int i = 0; i < K; i++) wd[i*DB +: DB] = DB'(i + 1);
        load_w(wd, hw);
        at_neg(hw + 17);
        check("build_end_w_ready", w_ready, 0);
        check("build_end_busy", busy, 1);
        at_neg(hw + 18);
        check("loaded_w_ready", w_ready, 1);
        check("loaded_x_ready", x_ready, 1);
        check("loaded_busy", busy, 0);
        @(posedge clk); #1;

        xd = '0;
        xd[DX-1:0] = 8'h81;
        send_x(xd, hx, 0);
        wait_drain();

        send_x(rand_x(), h1, 1);
        send_x(rand_x(), h2, 1);
        send_x(rand_x(), h3, 0);
        check("b2b_period_1", h2 - h1, DX + 2);
        check("b2b_period_2", h3 - h2, DX + 2);
        wait_drain();

        wd = rand_w();
        xd = rand_x();
        w_data = wd; x_data = xd;
        w_valid = 1'b1; x_valid = 1'b1;
        @(negedge clk); #1;
        check("prio_w_ready", w_ready, 1);
        check("prio_x_ready", x_ready, 0);
        hw = cyc;
        push_w(wd, hw);
        @(posedge clk); #1;
        w_valid = 1'b0;
        send_x(xd, hx, 0);
        check("prio_x_after_build", hx - hw, 18);
        wait_drain();

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) load_w(rand_w(), hw);
            repeat ($urandom_range(1, 3)) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                send_x(rand_x(), hx, 0);
            end
        end
        wait_drain();

        send_x(rand_x(), hx, 0);
        while (cyc < hx + 5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        wl_on = NEVER;
        sb.delete();
        #1;
        check_zero("reset_mid_compute");
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_x_probe("after_abort");

        load_w(rand_w(), hw);
        send_x(rand_x(), hx, 0);
        check("reload_x_latency", hx - hw, 18);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
